// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, parameter defaults and a counter-width helper.
package mem_port_arbiter_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 3;
    localparam int DEF_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Wait-cycle counter for an outstanding memory access; expired fires
// in the cycle that would complete TIMEOUT cycles without an ack.
module timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// with data priority, bounded fetch starvation and an ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_req,
    input  logic [DATA_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [DATA_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_ready,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_if,
    output logic              o_stall_mem,
    output logic              o_err
);

    localparam int            SW         = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [SW-1:0]     r_starve;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_we;
    logic              r_if_ready;
    logic              r_d_ready;
    logic              r_err;
    logic              w_busy;
    logic              w_grant_f;
    logic              w_grant_d;
    logic              w_finish;
    logic              w_expired;
    logic [DATA_W-1:0] w_rdata;

    assign w_busy = (r_state != IDLE);

    timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (!w_busy),
        .i_en     (w_busy && !i_mem_ack),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant_f = 1'b0;
        w_grant_d = 1'b0;
        w_finish  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // a starved fetch overrides the default data priority
                if (i_if_req && (!i_d_req || (r_starve == STARVE_LIM))) begin
                    w_grant_f = 1'b1;
                    w_next    = FETCH;
                end else if (i_d_req) begin
                    w_grant_d = 1'b1;
                    w_next    = DATA;
                end
            end
            FETCH, DATA: begin
                if (i_mem_ack || w_expired) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_rdata = i_mem_ack ? i_mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
            r_starve   <= '0;
        end else begin
            r_if_ready <= w_finish && (r_state == FETCH);
            r_d_ready  <= w_finish && (r_state == DATA);
            r_err      <= w_finish && !i_mem_ack;
            if (w_finish && (r_state == FETCH)) begin
                r_if_rdata <= w_rdata;
            end
            if (w_finish && (r_state == DATA)) begin
                r_d_rdata <= w_rdata;
            end
            if (w_grant_f) begin
                r_addr  <= i_if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end else if (w_grant_d) begin
                r_addr  <= i_d_addr;
                r_we    <= i_d_we;
                r_wdata <= i_d_wdata;
            end
            if (!i_if_req || w_grant_f) begin
                r_starve <= '0;
            end else if (w_grant_d && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign o_mem_req   = w_busy;
    assign o_mem_we    = r_we && (r_state == DATA);
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_ready   = r_d_ready;
    assign o_d_rdata   = r_d_rdata;
    assign o_err       = r_err;
    assign o_stall_if  = i_if_req && !r_if_ready;
    assign o_stall_mem = i_d_req && !r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case
// sequences and random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;
    localparam int STARVE  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ready;
    logic [31:0] o_if_rdata;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_ready;
    logic [31:0] o_d_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        o_stall_if;
    logic        o_stall_mem;
    logic        o_err;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .o_if_ready (o_if_ready),
        .o_if_rdata (o_if_rdata),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .o_d_ready  (o_d_ready),
        .o_d_rdata  (o_d_rdata),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata),
        .o_stall_if (o_stall_if),
        .o_stall_mem(o_stall_mem),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %h required %h", n, a, e);
        end
    endtask

    task automatic chkb(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %b required %b", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory contents as seen by completed accesses
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    bit          mon_on    = 0;
    bit          rand_dly  = 0;
    bit          junk_ack  = 0;
    bit          stale_ack = 0;
    int          next_delay = 0;
    logic [31:0] obs_addr [$];

    bit          m_busy = 0;
    bit          m_kf, m_we, prev_req = 0;
    logic [31:0] m_addr, m_wdata;
    int          m_cyc, m_delay, consec = 0;
    logic        e_ifr = 0, e_dr = 0, e_err = 0;
    logic [31:0] e_rdata = 0;

    function automatic int pick_delay();
        if (!rand_dly) return next_delay;
        if ($urandom_range(0, 15) == 0) return 40;
        return int'($urandom_range(0, 4));
    endfunction

    // Transaction model and memory responder: checks this cycle against
    // the expectations formed last cycle, then drives ack and forms new ones.
    always @(negedge clk) begin
        if (mon_on) begin
            chkb("mem_req", o_mem_req, m_busy);
            chkb("if_ready", o_if_ready, e_ifr);
            chkb("d_ready", o_d_ready, e_dr);
            chkb("err", o_err, e_err);
            chkb("stall_if", o_stall_if, i_if_req & ~e_ifr);
            chkb("stall_mem", o_stall_mem, i_d_req & ~e_dr);
            if (e_ifr) chk("if_rdata", o_if_rdata, e_rdata);
            if (e_dr) chk("d_rdata", o_d_rdata, e_rdata);
            if (m_busy) begin
                chk("mem_addr", o_mem_addr, m_addr);
                chkb("mem_we", o_mem_we, m_we);
                if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
            end
            if (o_mem_req && !prev_req) obs_addr.push_back(o_mem_addr);
            prev_req = o_mem_req;
            e_ifr = 0;
            e_dr = 0;
            e_err = 0;
            i_mem_ack = 0;
            i_mem_rdata = 0;
            if (reset) begin
                m_busy = 0;
                consec = 0;
            end else begin
                if (m_busy) begin
                    if (m_cyc == m_delay) begin
                        i_mem_ack = 1;
                        i_mem_rdata = rd(m_addr);
                        e_rdata = i_mem_rdata;
                        if (m_we) mem_m[m_addr] = m_wdata;
                        e_ifr = m_kf;
                        e_dr = !m_kf;
                        m_busy = 0;
                    end else if (m_cyc == TIMEOUT - 1) begin
                        e_rdata = 0;
                        e_err = 1;
                        e_ifr = m_kf;
                        e_dr = !m_kf;
                        m_busy = 0;
                    end
                    m_cyc++;
                end else begin
                    if (stale_ack || (junk_ack && $urandom_range(0, 5) == 0)) begin
                        i_mem_ack = 1;
                        i_mem_rdata = 32'hBAD0_BAD0;
                        stale_ack = 0;
                    end
                    if (i_if_req && (!i_d_req || consec == STARVE)) begin
                        m_busy = 1; m_kf = 1; m_we = 0;
                        m_addr = i_if_addr; m_wdata = 0;
                        m_cyc = 0; m_delay = pick_delay();
                        consec = 0;
                    end else if (i_d_req) begin
                        m_busy = 1; m_kf = 0; m_we = i_d_we;
                        m_addr = i_d_addr; m_wdata = i_d_wdata;
                        m_cyc = 0; m_delay = pick_delay();
                        if (consec < STARVE) consec++;
                    end
                end
                if (!i_if_req) consec = 0;
            end
        end
    end

    typedef struct {
        bit          f;
        logic [31:0] fa;
        bit          d;
        bit          we;
        logic [31:0] da;
        logic [31:0] wd;
        int          dly;
        int          lat_if;
        int          lat_d;
        logic [31:0] rd_if;
        logic [31:0] rd_d;
        bit          err;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        x;
        bit          fd, dd, fdone;
        int          n;
        logic [31:0] sx [5];

        vt[0] = '{1, 32'h04, 0, 0, 32'h0, 32'h0, 0, 2, 0, 32'h8C22_0000, 32'h0, 0};
        vt[1] = '{0, 32'h0, 1, 0, 32'h100, 32'h0, 2, 0, 4, 32'h0, 32'hDEAD_0100, 0};
        vt[2] = '{0, 32'h0, 1, 1, 32'h20, 32'h1234_5678, 1, 0, 3, 32'h0, 32'h5555_AAAA, 0};
        vt[3] = '{0, 32'h0, 1, 0, 32'h20, 32'h0, 0, 0, 2, 32'h0, 32'h1234_5678, 0};
        vt[4] = '{1, 32'h10, 1, 0, 32'h100, 32'h0, 0, 4, 2, 32'h0010_0013, 32'hDEAD_0100, 0};
        vt[5] = '{0, 32'h0, 1, 1, 32'h20, 32'hCAFE_F00D, 99, 0, 16, 32'h0, 32'h0, 1};
        vt[6] = '{1, 32'h08, 0, 0, 32'h0, 32'h0, 99, 16, 0, 32'h0, 32'h0, 1};
        vt[7] = '{1, 32'h04, 0, 0, 32'h0, 32'h0, 14, 16, 0, 32'h8C22_0000, 32'h0, 0};

        mem_m[32'h04]  = 32'h8C22_0000;
        mem_m[32'h10]  = 32'h0010_0013;
        mem_m[32'h100] = 32'hDEAD_0100;
        mem_m[32'h20]  = 32'h5555_AAAA;

        reset = 1;
        i_if_req = 0; i_if_addr = 0;
        i_d_req = 0; i_d_we = 0; i_d_addr = 0; i_d_wdata = 0;
        step();
        step();
        chkb("rst_mem_req", o_mem_req, 1'b0);
        chkb("rst_mem_we", o_mem_we, 1'b0);
        chkb("rst_if_ready", o_if_ready, 1'b0);
        chkb("rst_d_ready", o_d_ready, 1'b0);
        chkb("rst_err", o_err, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_if_rdata", o_if_rdata, 32'h0);
        chk("rst_d_rdata", o_d_rdata, 32'h0);
        mon_on = 1;
        reset = 0;
        step();

        for (int v = 0; v < 8; v++) begin
            x = vt[v];
            obs_addr.delete();
            next_delay = x.dly;
            i_if_req = x.f; i_if_addr = x.fa;
            i_d_req = x.d; i_d_we = x.we; i_d_addr = x.da; i_d_wdata = x.wd;
            fd = !x.f;
            dd = !x.d;
            for (int k = 1; k <= 40 && !(fd && dd); k++) begin
                step();
                if (!fd && o_if_ready) begin
                    chk("vec_if_lat", k, x.lat_if);
                    chk("vec_if_rdata", o_if_rdata, x.rd_if);
                    chkb("vec_if_err", o_err, x.err);
                    fd = 1;
                    i_if_req = 0;
                end
                if (!dd && o_d_ready) begin
                    chk("vec_d_lat", k, x.lat_d);
                    chk("vec_d_rdata", o_d_rdata, x.rd_d);
                    chkb("vec_d_err", o_err, x.err);
                    dd = 1;
                    i_d_req = 0;
                end
            end
            chkb("vec_done", fd && dd, 1'b1);
            chk("vec_grants", obs_addr.size(), int'(x.f) + int'(x.d));
            if (obs_addr.size() > 0)
                chk("vec_first_addr", obs_addr[0], x.d ? x.da : x.fa);
            if (obs_addr.size() > 1)
                chk("vec_second_addr", obs_addr[1], x.fa);
            step();
            step();
        end

        // fetch held across back-to-back loads
        obs_addr.delete();
        next_delay = 0;
        i_if_req = 1; i_if_addr = 32'h40;
        i_d_req = 1; i_d_we = 0; i_d_addr = 32'h200;
        n = 0;
        fdone = 0;
        for (int k = 0; k < 60 && !(n == 4 && fdone); k++) begin
            step();
            if (o_if_ready) begin
                fdone = 1;
                i_if_req = 0;
            end
            if (o_d_ready) begin
                n++;
                if (n < 4) i_d_addr = 32'h200 + 32'(4 * n);
                else i_d_req = 0;
            end
        end
        chk("starve_loads", n, 4);
        chkb("starve_fetch", fdone, 1'b1);
        chk("starve_grants", obs_addr.size(), 5);
        sx = '{32'h200, 32'h204, 32'h208, 32'h40, 32'h20C};
        for (int i = 0; i < 5; i++)
            if (i < obs_addr.size()) chk("starve_order", obs_addr[i], sx[i]);
        step();
        step();

        // reset during the second wait cycle of a load, then a stale ack
        next_delay = 99;
        i_d_req = 1; i_d_we = 0; i_d_addr = 32'h300;
        step();
        step();
        reset = 1;
        i_d_req = 0;
        step();
        chkb("rst_mid_mem_req", o_mem_req, 1'b0);
        reset = 0;
        stale_ack = 1;
        step();
        chkb("stale_d_ready", o_d_ready, 1'b0);
        chk("stale_d_rdata", o_d_rdata, 32'h0);
        chkb("stale_mem_req", o_mem_req, 1'b0);
        step();
        step();

        // requester drops d_req while its access is outstanding
        next_delay = 3;
        i_d_req = 1; i_d_we = 0; i_d_addr = 32'h100;
        step();
        i_d_req = 0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (o_d_ready) begin
                n++;
                chk("drop_lat", k + 2, 5);
                chk("drop_rdata", o_d_rdata, 32'hDEAD_0100);
            end
        end
        chk("drop_pulses", n, 1);
        chk("drop_hold", o_d_rdata, 32'hDEAD_0100);

        // random traffic
        rand_dly = 1;
        junk_ack = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (o_if_ready) i_if_req = 0;
            if (o_d_ready) i_d_req = 0;
            if (!i_if_req && $urandom_range(0, 2) == 0) begin
                i_if_req = 1;
                i_if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!i_d_req && $urandom_range(0, 1) == 0) begin
                i_d_req = 1;
                i_d_we = 1'($urandom_range(0, 1));
                i_d_addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
                i_d_wdata = $urandom;
            end
        end
        for (int k = 0; k < 100 && (i_if_req || i_d_req); k++) begin
            step();
            if (o_if_ready) i_if_req = 0;
            if (o_d_ready) i_d_req = 0;
        end
        chkb("drain", i_if_req | i_d_req, 1'b0);
        junk_ack = 0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of the address and data buses.
REQ-002 Parameter STARVE_MAX, default 3: maximum consecutive data grants while a fetch is pending.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ack.
REQ-004 clk  in  1  clock; reset is synchronous and active-high; all state updates on the rising edge of clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  instruction fetch request; held until if_ready.
REQ-007 if_addr  in  DATA_W  fetch address (the PC).
REQ-008 if_ready  out  1  one-cycle pulse; fetch complete.
REQ-009 if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
REQ-010 d_req  in  1  data (load/store) request; held until d_ready.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr, d_wdata  in  DATA_W  data address and store data.
REQ-013 d_ready  out  1  one-cycle pulse; data access complete.
REQ-014 d_rdata  out  DATA_W  load data; valid while d_ready=1.
REQ-015 mem_req, mem_we  out  1  single-port memory request and write enable.
REQ-016 mem_addr, mem_wdata  out  DATA_W  memory address and write data.
REQ-017 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-018 mem_rdata  in  DATA_W  memory read data.
REQ-019 stall_if, stall_mem  out  1  pipeline stalls: stall_if = if_req & ~if_ready; stall_mem = d_req & ~d_ready.
REQ-020 err  out  1  one-cycle pulse on a memory timeout.

Function
REQ-021 The FSM SHALL have three states: IDLE, FETCH and DATA.
REQ-022 IDLE, d_req=1: go to DATA, except when if_req=1 and starve_cnt=STARVE_MAX, which goes to FETCH.
REQ-023 IDLE, d_req=0 and if_req=1: go to FETCH; with no request, stay in IDLE.
REQ-024 On entering FETCH or DATA, the arbiter SHALL register addr, we and wdata from the winner and drive them from the next cycle until ack.
REQ-025 mem_req SHALL be 1 only in FETCH or DATA; mem_we SHALL be 0 in FETCH.
REQ-026 mem_ack in FETCH or DATA SHALL register mem_rdata, go to IDLE, and pulse the matching ready exactly one cycle later.
REQ-027 Minimum latency: request sampled at edge t, mem_req high after t, ack in the same cycle, ready pulse in cycle t+2.
REQ-028 A back-to-back request is re-arbitrated in the IDLE cycle that coincides with the ready pulse.
REQ-029 A requester that lowers req mid-access SHALL NOT abort the access; the ready pulse is still issued.
REQ-030 starve_cnt (sized for STARVE_MAX) SHALL increment on each DATA grant while if_req=1, saturating at STARVE_MAX.
REQ-031 starve_cnt SHALL clear on any FETCH grant or whenever if_req=0.
REQ-032 wait_cnt SHALL count cycles in FETCH/DATA without ack.
REQ-033 When wait_cnt reaches TIMEOUT, the arbiter SHALL go to IDLE, pulse err, pulse the matching ready with rdata=0, and drop mem_req.
REQ-034 mem_ack in IDLE SHALL be ignored: no ready pulse and no state change.
REQ-035 A store SHALL complete on ack; d_rdata SHALL then be the registered mem_rdata, which carries no meaning for a store.
REQ-036 if_rdata and d_rdata SHALL hold their last value between pulses.

Reset
REQ-037 On reset the arbiter SHALL enter IDLE.
REQ-038 On reset mem_req, mem_we, if_ready, d_ready and err SHALL be 0.
REQ-039 On reset the registered address, data and rdata SHALL be 0, and starve_cnt and wait_cnt SHALL be 0.
REQ-040 Reset mid-access SHALL abandon the access: mem_req is 0 in the cycle after reset, and a later stale mem_ack is ignored.

Structure
REQ-041 A shared package SHALL hold the state enumeration (IDLE, FETCH, DATA) and the default values of DATA_W, STARVE_MAX and TIMEOUT.
REQ-042 The wait/timeout counter SHALL be one sub-module, timeout_counter, with inputs clr and en and output expired.

Verification
REQ-043 Fetch, zero-wait memory: if_req=1, if_addr=0x04, mem_ack in the first mem_req cycle with rdata=0x8C220000 -> if_ready in cycle t+2 with that value; stall_if=1 for cycles t..t+1.
REQ-044 Simultaneous fetch and load: if_req and d_req both 1 at 0x10 and 0x100 -> DATA is served first (mem_addr=0x100), then FETCH at 0x10.
REQ-045 Starvation: if_req held for 4 back-to-back loads with STARVE_MAX=3 -> grants are D, D, D, F, D.
REQ-046 Timeout: mem_ack never asserted on a store to 0x20 -> after 15 cycles, err and d_ready pulse together and mem_req drops.
REQ-047 Reset mid-access: reset during DATA wait cycle 2 -> IDLE, mem_req=0 next cycle, and an ack arriving 1 cycle after reset produces no ready.
REQ-048 Request dropped: d_req lowered 1 cycle into DATA, ack after 3 cycles -> the access completes and d_ready pulses once.
